// File: rtl/commit_trace_buffer_if.sv
// Bundle of capture, control, status and readout signals for commit_trace_buffer.
// The trace buffer uses the slave modport; whoever drives the core side and drains records uses master.
interface commit_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              cap_valid;
  logic [DATA_W-1:0] cap_pc;
  logic [DATA_W-1:0] cap_instr;
  logic [DATA_W-1:0] cap_wdata;
  logic              mode;
  logic              trig_en;
  logic [DATA_W-1:0] trig_pc;
  logic              arm;
  logic              stop;
  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic              triggered;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_instr;
  logic [DATA_W-1:0] rd_wdata;
  logic              rd_last;

  modport master (
    output cap_valid, cap_pc, cap_instr, cap_wdata,
    output mode, trig_en, trig_pc, arm, stop, rd_ready,
    input  state, count, triggered,
    input  rd_valid, rd_pc, rd_instr, rd_wdata, rd_last
  );

  modport slave (
    input  cap_valid, cap_pc, cap_instr, cap_wdata,
    input  mode, trig_en, trig_pc, arm, stop, rd_ready,
    output state, count, triggered,
    output rd_valid, rd_pc, rd_instr, rd_wdata, rd_last
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Circular capture buffer of retired-instruction records (PC, instruction, write data)
// with wrap / stop-on-trigger capture and oldest-first valid/ready readout.
module commit_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  commit_trace_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = 3 * DATA_W;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("commit_trace_buffer: DEPTH must be a power of two >= 4");
  end
  if (POST_TRIG < 0 || POST_TRIG > DEPTH - 1) begin : g_bad_post
    $error("commit_trace_buffer: POST_TRIG must lie in 0..DEPTH-1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] post_cnt_q, post_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic          triggered_q, triggered_d;
  logic [RW-1:0] mem_q [DEPTH];

  logic          capturing;
  logic          wr_en;
  logic          trig_ev;
  logic          rd_valid;
  logic          rd_accept;
  logic [PW-1:0] rd_ptr;
  logic [RW-1:0] rd_rec;

  assign capturing = (state_q == S_CAPTURE) || (state_q == S_POST);
  assign wr_en     = capturing && bus.cap_valid && !bus.arm;
  assign trig_ev   = (state_q == S_CAPTURE) && bus.cap_valid && bus.trig_en &&
                     (bus.cap_pc == bus.trig_pc);
  assign rd_valid  = (state_q == S_DONE) && (count_q != '0);
  assign rd_accept = rd_valid && bus.rd_ready;
  // When count==DEPTH the low bits are zero, so the oldest record sits at wr_ptr itself.
  assign rd_ptr    = wr_ptr_q - count_q[PW-1:0];
  assign rd_rec    = mem_q[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.arm) begin
      state_d = S_CAPTURE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_CAPTURE: begin
          if (bus.stop) begin
            state_d = S_DONE;
          end else if (trig_ev && bus.mode) begin
            state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (bus.stop || (bus.cap_valid && post_cnt_q == PW'(1))) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (count_q == '0 || (rd_accept && count_q == CW'(1))) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    triggered_d = triggered_q;
    post_cnt_d  = post_cnt_q;
    if (bus.arm) begin
      wr_ptr_d    = '0;
      count_d     = '0;
      triggered_d = 1'b0;
      post_cnt_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        count_d  = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
      end
      if (trig_ev) begin
        triggered_d = 1'b1;
        if (bus.mode && !bus.stop) begin
          post_cnt_d = PW'(POST_TRIG);
        end
      end
      if (state_q == S_POST && bus.cap_valid) begin
        post_cnt_d = post_cnt_q - PW'(1);
      end
      if (rd_accept) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_comb begin
    bus.state     = state_q;
    bus.count     = count_q;
    bus.triggered = triggered_q;
    bus.rd_valid  = rd_valid;
    bus.rd_last   = rd_valid && (count_q == CW'(1));
    bus.rd_pc     = '0;
    bus.rd_instr  = '0;
    bus.rd_wdata  = '0;
    if (rd_valid) begin
      bus.rd_pc    = rd_rec[RW-1 -: DATA_W];
      bus.rd_instr = rd_rec[2*DATA_W-1 -: DATA_W];
      bus.rd_wdata = rd_rec[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      post_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      triggered_q <= triggered_d;
      post_cnt_q  <= post_cnt_d;
    end
  end

  // Record storage is deliberately left out of reset so stale contents survive it.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en) begin
      mem_q[wr_ptr_q] <= {bus.cap_pc, bus.cap_instr, bus.cap_wdata};
    end
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed vector table, hand-written
// corner sequences, then randomized traffic compared against a queue-based reference model.
module tb_commit_trace_buffer;

  localparam int DEPTH = 8;
  localparam int PT_A  = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wdata;
  } rec_t;

  typedef struct {
    bit          arm;
    bit          stop;
    bit          capValid;
    logic [31:0] pc;
    bit          rdReady;
    int          expState;
    int          expCount;
    bit          expRv;
    logic [31:0] expPc;
    bit          expLast;
  } vec_t;

  logic        clk;
  logic        rstn;
  logic        capValid, mode, trigEn, arm, stop, rdReady;
  logic [31:0] capPc, capInstr, capWdata, trigPc;

  int checks;
  int errors;

  rec_t mQ[$];
  int   mSt;
  bit   mTrig;
  int   mPost;

  commit_trace_buffer_if #(.DATA_W(32), .DEPTH(DEPTH)) busA ();
  commit_trace_buffer_if #(.DATA_W(32), .DEPTH(DEPTH)) busB ();

  assign busA.cap_valid = capValid;
  assign busA.cap_pc    = capPc;
  assign busA.cap_instr = capInstr;
  assign busA.cap_wdata = capWdata;
  assign busA.mode      = mode;
  assign busA.trig_en   = trigEn;
  assign busA.trig_pc   = trigPc;
  assign busA.arm       = arm;
  assign busA.stop      = stop;
  assign busA.rd_ready  = rdReady;

  assign busB.cap_valid = capValid;
  assign busB.cap_pc    = capPc;
  assign busB.cap_instr = capInstr;
  assign busB.cap_wdata = capWdata;
  assign busB.mode      = mode;
  assign busB.trig_en   = trigEn;
  assign busB.trig_pc   = trigPc;
  assign busB.arm       = arm;
  assign busB.stop      = stop;
  assign busB.rd_ready  = rdReady;

  commit_trace_buffer #(.DATA_W(32), .DEPTH(DEPTH), .POST_TRIG(PT_A)) dutA (
    .clk_i (clk),
    .rst_ni(rstn),
    .bus   (busA)
  );

  commit_trace_buffer #(.DATA_W(32), .DEPTH(DEPTH), .POST_TRIG(0)) dutB (
    .clk_i (clk),
    .rst_ni(rstn),
    .bus   (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the buffer is a queue of at most DEPTH records, oldest at the front.
  task automatic pushRec(input rec_t r);
    mQ.push_back(r);
    if (mQ.size() > DEPTH) void'(mQ.pop_front());
  endtask

  task automatic modelStep();
    rec_t r;
    bit   ev;
    r = {capPc, capInstr, capWdata};
    if (!rstn) begin
      mSt = 0; mQ.delete(); mTrig = 0; mPost = 0;
      return;
    end
    if (arm) begin
      mSt = 1; mQ.delete(); mTrig = 0;
      return;
    end
    case (mSt)
      1: begin
        ev = capValid && trigEn && (capPc == trigPc);
        if (capValid) pushRec(r);
        if (ev) mTrig = 1;
        if (stop) mSt = 3;
        else if (ev && mode) begin
          if (PT_A == 0) mSt = 3;
          else begin mSt = 2; mPost = PT_A; end
        end
      end
      2: begin
        if (capValid) begin
          pushRec(r);
          mPost--;
          if (mPost == 0) mSt = 3;
        end
        if (stop) mSt = 3;
      end
      3: begin
        if (mQ.size() == 0) mSt = 0;
        else if (rdReady) begin
          void'(mQ.pop_front());
          if (mQ.size() == 0) mSt = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input bit a, input bit s, input bit cv,
                               input logic [31:0] pc, input bit rr);
    arm      = a;
    stop     = s;
    capValid = cv;
    capPc    = pc;
    capInstr = $urandom();
    capWdata = $urandom();
    rdReady  = rr;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkA(input string tag, input int st, input int cnt, input bit rv,
                        input logic [31:0] rpc, input bit last);
    checkOutput({tag, ".state"},    32'(busA.state),    32'(st));
    checkOutput({tag, ".count"},    32'(busA.count),    32'(cnt));
    checkOutput({tag, ".rd_valid"}, 32'(busA.rd_valid), 32'(rv));
    checkOutput({tag, ".rd_pc"},    busA.rd_pc,         rpc);
    checkOutput({tag, ".rd_last"},  32'(busA.rd_last),  32'(last));
  endtask

  task automatic checkB(input string tag, input int st, input int cnt, input bit rv,
                        input logic [31:0] rpc, input bit last);
    checkOutput({tag, ".state"},    32'(busB.state),    32'(st));
    checkOutput({tag, ".count"},    32'(busB.count),    32'(cnt));
    checkOutput({tag, ".rd_valid"}, 32'(busB.rd_valid), 32'(rv));
    checkOutput({tag, ".rd_pc"},    busB.rd_pc,         rpc);
    checkOutput({tag, ".rd_last"},  32'(busB.rd_last),  32'(last));
  endtask

  initial begin
    vec_t tbl[$];
    bit   pat[4];
    int   idx;
    bit   expRv;
    rec_t expRec;

    checks = 0; errors = 0;
    mSt = 0; mTrig = 0; mPost = 0;
    rstn = 1'b0;
    capValid = 0; mode = 0; trigEn = 0; arm = 0; stop = 0; rdReady = 0;
    capPc = '0; capInstr = '0; capWdata = '0; trigPc = '0;

    // Reset held two cycles, with stray capture and readout activity ignored.
    applyStimulus(0, 0, 1, 32'h0, 1);
    applyStimulus(0, 1, 1, 32'h4, 1);
    checkA("reset", 0, 0, 0, 32'h0, 0);
    checkOutput("reset.triggered", 32'(busA.triggered), 32'h0);
    checkB("resetB", 0, 0, 0, 32'h0, 0);
    rstn = 1'b1;

    // Wrap mode: 12 records into 8 slots, stop, then drain the newest 8 oldest-first.
    mode = 0; trigEn = 0;
    tbl.push_back('{1, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0});
    for (int i = 0; i < 12; i++)
      tbl.push_back('{0, 0, 1, 32'(4 * i), 0, 1, (i + 1 > 8) ? 8 : i + 1, 0, 32'h0, 0});
    tbl.push_back('{0, 1, 0, 32'h0, 0, 3, 8, 1, 32'h10, 0});
    for (int k = 0; k < 8; k++) begin
      if (k < 7) tbl.push_back('{0, 0, 0, 32'h0, 1, 3, 7 - k, 1, 32'(32'h14 + 4 * k), k == 6});
      else       tbl.push_back('{0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0});
    end
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].arm, tbl[i].stop, tbl[i].capValid, tbl[i].pc, tbl[i].rdReady);
      checkA($sformatf("wrap[%0d]", i), tbl[i].expState, tbl[i].expCount,
             tbl[i].expRv, tbl[i].expPc, tbl[i].expLast);
    end

    // Stop-on-trigger at 0x18 with two post-trigger records; later records are blocked.
    mode = 1; trigEn = 1; trigPc = 32'h18;
    applyStimulus(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(0, 0, 1, 32'(4 * i), 0);
      if (i == 6) begin
        checkOutput("trig.post_state", 32'(busA.state), 32'h2);
        checkOutput("trig.triggered", 32'(busA.triggered), 32'h1);
      end
      if (i == 8) checkA("trig.done", 3, 8, 1, 32'h4, 0);
    end
    checkA("trig.hold", 3, 8, 1, 32'h4, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 0, 32'h0, 1);
      if (k < 7) checkA($sformatf("trig.rd[%0d]", k), 3, 7 - k, 1, 32'(32'h8 + 4 * k), k == 6);
      else       checkA("trig.rd_end", 0, 0, 0, 32'h0, 0);
    end

    // POST_TRIG=0 instance finishes on the trigger record itself; instance A enters POST.
    trigPc = 32'h8;
    applyStimulus(1, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 1, 32'h0, 0);
    applyStimulus(0, 0, 1, 32'h4, 0);
    checkOutput("pt0.pre_state", 32'(busB.state), 32'h1);
    applyStimulus(0, 0, 1, 32'h8, 0);
    checkB("pt0.done", 3, 3, 1, 32'h0, 0);
    checkOutput("pt0.triggered", 32'(busB.triggered), 32'h1);
    checkOutput("post.state", 32'(busA.state), 32'h2);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkB("pt0.rd1", 3, 2, 1, 32'h4, 0);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkB("pt0.rd2", 3, 1, 1, 32'h8, 1);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkB("pt0.rd_end", 0, 0, 0, 32'h0, 0);

    // arm and stop together while in POST: arm wins and clears everything.
    applyStimulus(1, 1, 0, 32'h0, 0);
    checkA("armstop", 1, 0, 0, 32'h0, 0);
    checkOutput("armstop.triggered", 32'(busA.triggered), 32'h0);

    // Readout with rd_ready toggling 1,0,0,1: record held while stalled.
    mode = 0; trigEn = 0;
    applyStimulus(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 32'(32'h40 + 4 * i), 0);
    applyStimulus(0, 1, 0, 32'h0, 0);
    checkA("stall.start", 3, 4, 1, 32'h40, 0);
    pat = '{1, 0, 0, 1};
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 32'h0, pat[i % 4]);
      if (pat[i % 4]) idx++;
      if (idx < 4) checkA($sformatf("stall[%0d]", i), 3, 4 - idx, 1, 32'(32'h40 + 4 * idx), idx == 3);
      else         checkA($sformatf("stall[%0d]", i), 0, 0, 0, 32'h0, 0);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      bit a;
      rstn = ($urandom_range(299) != 0);
      a = ($urandom_range(39) == 0);
      if (a) begin
        mode   = 1'($urandom_range(1));
        trigEn = 1'($urandom_range(1));
        trigPc = 32'($urandom_range(15)) << 2;
      end
      applyStimulus(a, $urandom_range(29) == 0, $urandom_range(9) < 7,
                    32'($urandom_range(15)) << 2, $urandom_range(9) < 6);
      expRv  = (mSt == 3) && (mQ.size() != 0);
      expRec = expRv ? mQ[0] : '0;
      checkOutput($sformatf("rnd[%0d].state", c),     32'(busA.state),     32'(mSt));
      checkOutput($sformatf("rnd[%0d].count", c),     32'(busA.count),     32'(mQ.size()));
      checkOutput($sformatf("rnd[%0d].triggered", c), 32'(busA.triggered), 32'(mTrig));
      checkOutput($sformatf("rnd[%0d].rd_valid", c),  32'(busA.rd_valid),  32'(expRv));
      checkOutput($sformatf("rnd[%0d].rd_pc", c),     busA.rd_pc,          expRec.pc);
      checkOutput($sformatf("rnd[%0d].rd_instr", c),  busA.rd_instr,       expRec.instr);
      checkOutput($sformatf("rnd[%0d].rd_wdata", c),  busA.rd_wdata,       expRec.wdata);
      checkOutput($sformatf("rnd[%0d].rd_last", c),   32'(busA.rd_last),
                  32'(expRv && mQ.size() == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Parametrised commit-trace capture buffer for the MIPS cores. It samples one retired-instruction record per valid cycle (PC, instruction word, register write data) into a circular buffer. Capture runs in wrap or stop-on-trigger mode, and the buffer is drained oldest-first over a valid/ready port. It sits beside Top_single (and its pipelined successors) as an on-chip replacement for waveform-only debugging.

## Interface
Parameters:
- DATA_W, 32, width of each record field (PC, instruction, write data)
- DEPTH, 16, number of records; power of two, ≥ 4
- POST_TRIG, 4, records captured after the trigger record; legal range 0..DEPTH-1

Ports:
- CLK  in  1  clock; all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- cap_valid  in  1  a record is presented this cycle
- cap_pc  in  DATA_W  PC of retired instruction
- cap_instr  in  DATA_W  instruction word
- cap_wdata  in  DATA_W  register-file write data
- mode  in  1  0 = wrap (continuous), 1 = stop-on-trigger
- trig_en  in  1  enables PC-match trigger
- trig_pc  in  DATA_W  trigger PC value
- arm  in  1  single-cycle pulse: clear buffer, start capture
- stop  in  1  single-cycle pulse: end capture, enter readout
- state  out  2  0 IDLE, 1 CAPTURE, 2 POST, 3 DONE
- count  out  $clog2(DEPTH)+1  records held
- triggered  out  1  trigger seen since last arm
- rd_valid  out  1  readout record available
- rd_ready  in  1  consumer accepts record
- rd_pc, rd_instr, rd_wdata  out  DATA_W  readout record, forced to 0 while rd_valid=0
- rd_last  out  1  current readout record is the final one

## Operation
- Reset (RESET=0 at an edge): state=IDLE, count=0, triggered=0, write/read pointers=0, rd_valid=0, rd_*=0, rd_last=0. Buffer contents are not cleared.
- Trigger event: cap_valid && trig_en && cap_pc==trig_pc, evaluated in CAPTURE only.
- IDLE:
  - arm → CAPTURE. Pointers, count and triggered are cleared.
  - cap_valid, stop and rd_ready are ignored.
- CAPTURE: each cap_valid writes the record at wr_ptr. wr_ptr increments mod DEPTH. count increments, saturating at DEPTH; at DEPTH the oldest record is overwritten.
  - mode=0: a trigger event sets triggered and capture continues. stop → DONE.
  - mode=1: a trigger event writes its own record and sets triggered. If POST_TRIG=0 → DONE, otherwise → POST with post_cnt=POST_TRIG. stop → DONE.
- POST: each cap_valid writes a record and decrements post_cnt. The write that takes post_cnt to 0 → DONE. stop → DONE. Further trigger events are ignored.
- DONE:
  - Writes are blocked.
  - rd_valid = (count≠0). Read pointer = wr_ptr − count (mod DEPTH), so records drain oldest-first.
  - Each rd_valid && rd_ready advances the read pointer and decrements count.
  - rd_last = rd_valid && count==1.
  - Acceptance of the last record → IDLE. DONE with count=0 → IDLE next cycle.
- arm has priority over stop and over readout in every state. arm in CAPTURE/POST/DONE restarts capture and discards contents.
- stop in IDLE is ignored.
- Pointer arithmetic is mod DEPTH. count never exceeds DEPTH.

## Timing
- Write latency: a record sampled at edge N appears in count after edge N. It is readable once state=DONE.
- A trigger record's state change (→POST/DONE) and triggered=1 are visible the cycle after the sampling edge.
- rd_* are combinational from the buffer at the read pointer; the record is valid in the same cycle rd_valid rises. Throughput is one record per cycle with rd_ready held high.
- rd_valid rises in the first cycle state=DONE when count>0.
- rd_valid, once high, stays high with a stable record until accepted, or until arm or reset.
- Same-cycle cap_valid and stop in CAPTURE/POST: the record is written, then → DONE.
- Reset mid-readout drops the remaining records. rd_valid=0 the next cycle.

## Test plan
- DEPTH=8, POST_TRIG=2: reset held 2 cycles → state=0, count=0, rd_valid=0, rd_pc=0.
- mode=0, arm, 12 records with PC=0x00,0x04..0x2C, then stop → count=8; readout with rd_ready=1 gives PC 0x10..0x2C in order, rd_last only on 0x2C, then state=0.
- mode=1, trig_pc=0x18, records PC=0x00..0x30 step 4 → capture ends after PC 0x20; triggered=1; count=9 saturated to 8; readout PC 0x04..0x20.
- mode=1, POST_TRIG=0, trig_pc=0x08, records PC 0x00,0x04,0x08 → DONE the cycle after 0x08; count=3; readout 0x00,0x04,0x08.
- Readout with rd_ready toggling 1,0,0,1 → record held stable while rd_ready=0; no record lost or duplicated.
- arm and stop asserted together during POST → state=CAPTURE, count=0, triggered=0.
